// File: rtl/apb_pkg.sv
// Shared constants for the APB completer: FSM state encodings, wait-counter width
// and PSLVERR response encodings.
package apb_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic PSLVERR_OKAY = 1'b0;
   localparam logic PSLVERR_ERR  = 1'b1;

endpackage

// File: rtl/apb_completer_regs_if.sv
// APB bus bundle between a requester (master) and the register completer (slave).
interface apb_completer_regs_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic                  PSEL_i;
   logic                  PENABLE_i;
   logic                  PWRITE_i;
   logic [ADDR_WIDTH-1:0] PADDR_i;
   logic [DATA_WIDTH-1:0] PWRDATA_i;
   logic [DATA_WIDTH-1:0] PRDATA_o;
   logic                  PREADY_o;
   logic                  PSLVERR_o;

   modport master (
      output PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWRDATA_i,
      input  PRDATA_o, PREADY_o, PSLVERR_o
   );

   modport slave (
      input  PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWRDATA_i,
      output PRDATA_o, PREADY_o, PSLVERR_o
   );

endinterface

// File: rtl/apb_reg_array.sv
// DEPTH x DATA_WIDTH register storage: synchronous write, combinational read,
// asynchronous clear to zero.
module apb_reg_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int IDX_W      = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Storage update: cleared on reset, one word written per enabled edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer holding a word-addressed register file, with a fixed number of
// wait states per access and PSLVERR on out-of-range addresses.
module apb_completer_regs
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 PCLK_i,
   input  logic                 PRESETn_i,
   apb_completer_regs_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [1:0]            state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [IDX_W-1:0]      addr_q,    addr_d;
   logic                  write_q,   write_d;
   logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
   logic                  err_q,     err_d;
   logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
   logic                  pready_q,  pready_d;
   logic                  pslverr_q, pslverr_d;

   logic                  setup_err_s;
   logic                  enter_done_s;
   logic                  clear_s;
   logic                  ent_err_s;
   logic                  ent_write_s;
   logic                  we_s;
   logic [IDX_W-1:0]      rd_idx_s;
   logic [DATA_WIDTH-1:0] rdata_s;

   // Any address at or beyond DEPTH (including nonzero upper bits) is an error.
   assign setup_err_s = (bus.PADDR_i >= ADDR_WIDTH'(DEPTH));

   // With zero wait states the read happens on the SETUP edge, before addr_q is loaded.
   assign rd_idx_s = (state_q == ST_IDLE) ? bus.PADDR_i[IDX_W-1:0] : addr_q;

   apb_reg_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_reg_array (
      .clk_i   (PCLK_i),
      .rst_ni  (PRESETn_i),
      .we_i    (we_s),
      .waddr_i (addr_q),
      .wdata_i (wdata_q),
      .raddr_i (rd_idx_s),
      .rdata_o (rdata_s)
   );

   // Next-state logic for the transfer FSM and its registered outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      prdata_d     = prdata_q;
      pready_d     = pready_q;
      pslverr_d    = pslverr_q;
      enter_done_s = 1'b0;
      clear_s      = 1'b0;
      ent_err_s    = 1'b0;
      ent_write_s  = 1'b0;
      we_s         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.PSEL_i && !bus.PENABLE_i) begin
               addr_d  = bus.PADDR_i[IDX_W-1:0];
               write_d = bus.PWRITE_i;
               wdata_d = bus.PWRDATA_i;
               err_d   = setup_err_s;
               if (WAIT_CYCLES == 0) begin
                  state_d      = ST_DONE;
                  cnt_d        = '0;
                  enter_done_s = 1'b1;
                  ent_err_s    = setup_err_s;
                  ent_write_s  = bus.PWRITE_i;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!bus.PSEL_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               clear_s = 1'b1;
            end else if (bus.PENABLE_i) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d      = ST_DONE;
                  cnt_d        = '0;
                  enter_done_s = 1'b1;
                  ent_err_s    = err_q;
                  ent_write_s  = write_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (!bus.PSEL_i) begin
               state_d = ST_IDLE;
               clear_s = 1'b1;
            end else if (bus.PENABLE_i && pready_q) begin
               we_s    = write_q && !err_q;
               state_d = ST_IDLE;
               clear_s = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clear_s = 1'b1;
         end
      endcase

      if (enter_done_s) begin
         pready_d  = 1'b1;
         pslverr_d = ent_err_s ? PSLVERR_ERR : PSLVERR_OKAY;
         if (ent_write_s) begin
            prdata_d = prdata_q;
         end else if (ent_err_s) begin
            prdata_d = '0;
         end else begin
            prdata_d = rdata_s;
         end
      end else if (clear_s) begin
         pready_d  = 1'b0;
         pslverr_d = PSLVERR_OKAY;
      end else begin
         pready_d  = pready_q;
         pslverr_d = pslverr_q;
      end
   end

   // State and output registers.
   always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
      if (!PRESETn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign bus.PRDATA_o  = prdata_q;
   assign bus.PREADY_o  = pready_q;
   assign bus.PSLVERR_o = pslverr_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: three instances (1, 0 and 3 wait states) driven by
// directed and random APB transfers, checked against an array-based memory model.
module tb_apb_completer_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel    [3];
   logic        penable [3];
   logic        pwrite  [3];
   logic [31:0] paddr   [3];
   logic [31:0] pwdata  [3];
   wire  [31:0] prdata_w  [3];
   wire         pready_w  [3];
   wire         pslverr_w [3];

   logic [31:0] ref_mem    [3][32];
   logic [31:0] exp_prdata [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      apb_completer_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_bus ();
      assign u_bus.PSEL_i    = psel[g];
      assign u_bus.PENABLE_i = penable[g];
      assign u_bus.PWRITE_i  = pwrite[g];
      assign u_bus.PADDR_i   = paddr[g];
      assign u_bus.PWRDATA_i = pwdata[g];
      assign prdata_w[g]     = u_bus.PRDATA_o;
      assign pready_w[g]     = u_bus.PREADY_o;
      assign pslverr_w[g]    = u_bus.PSLVERR_o;
      apb_completer_regs #(
         .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_CYCLES(WC)
      ) u_dut (
         .PCLK_i    (clk),
         .PRESETn_i (rst_n),
         .bus       (u_bus)
      );
   end

   function automatic int wc(input int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         exp_prdata[d] = 32'd0;
         for (int a = 0; a < 32; a++) ref_mem[d][a] = 32'd0;
      end
   endtask

   task automatic bus_idle_all();
      for (int d = 0; d < 3; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = 32'd0; pwdata[d] = 32'd0;
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk({tag, "_prdata"},  prdata_w[d],         32'd0);
         chk({tag, "_pready"},  32'(pready_w[d]),    32'd0);
         chk({tag, "_pslverr"}, 32'(pslverr_w[d]),   32'd0);
      end
   endtask

   // Starts #1 after a rising edge; ends #1 after the completion edge with the bus still driven.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
      int          cyc;
      bit          exp_err;
      logic [31:0] exp_rd;
      exp_err = (addr >= 32'd32);
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
      @(negedge clk);
      chk("setup_pready", 32'(pready_w[d]), 32'd0);
      @(posedge clk); #1;
      penable[d] = 1'b1;
      cyc = 2;
      @(negedge clk);
      while (pready_w[d] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("xfer_len", cyc, 32'(2 + wc(d)));
      chk("pslverr", 32'(pslverr_w[d]), 32'(exp_err));
      if (wr) begin
         chk("wr_prdata_hold", prdata_w[d], exp_prdata[d]);
      end else begin
         exp_rd = exp_err ? 32'd0 : ref_mem[d][addr[4:0]];
         chk("rd_prdata", prdata_w[d], exp_rd);
         exp_prdata[d] = exp_rd;
      end
      @(posedge clk); #1;
      if (wr && !exp_err) ref_mem[d][addr[4:0]] = wd;
   endtask

   task automatic idle(input int d, input int n);
      psel[d] = 1'b0; penable[d] = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle_pready", 32'(pready_w[d]), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   // Write that is abandoned by dropping PSEL after n_acc ACCESS cycles (n_acc < wait states).
   task automatic abort_write(input int d, input logic [31:0] addr, input logic [31:0] wd, input int n_acc);
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = addr; pwdata[d] = wd;
      @(posedge clk); #1;
      repeat (n_acc) begin
         penable[d] = 1'b1;
         @(negedge clk);
         chk("abort_wait_pready", 32'(pready_w[d]), 32'd0);
         @(posedge clk); #1;
      end
      idle(d, 3);
   endtask

   initial begin
      int          d;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;

      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          d;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;

      rst_n = 1'b0;
      bus_idle_all();
      model_reset();
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First read after reset: 3-cycle transfer returning zero.
      xfer(0, 1'b0, 32'd5, 32'd0);
      idle(0, 1);

      xfer(0, 1'b1, 32'd14, 32'd25);
      xfer(0, 1'b1, 32'd12, 32'd20);
      xfer(0, 1'b1, 32'd30, 32'd50);
      xfer(0, 1'b0, 32'd14, 32'd0);
      xfer(0, 1'b0, 32'd12, 32'd0);
      xfer(0, 1'b0, 32'd30, 32'd0);
      idle(0, 1);

      // Out-of-range accesses leave the array untouched.
      xfer(0, 1'b1, 32'd0, 32'h1234);
      xfer(0, 1'b1, 32'd32, 32'hDEAD);
      xfer(0, 1'b0, 32'd32, 32'd0);
      xfer(0, 1'b0, 32'd0, 32'd0);
      xfer(0, 1'b1, 32'h8000_0000, 32'hBEEF);
      xfer(0, 1'b0, 32'd0, 32'd0);
      idle(0, 1);

      // Back-to-back write then read on the 0- and 3-wait-state instances.
      xfer(1, 1'b1, 32'd1, 32'd13);
      xfer(1, 1'b0, 32'd1, 32'd0);
      idle(1, 1);
      xfer(2, 1'b1, 32'd1, 32'd13);
      xfer(2, 1'b0, 32'd1, 32'd0);
      idle(2, 1);

      // PENABLE without SETUP is ignored.
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'd14;
      repeat (3) begin
         @(negedge clk);
         chk("no_setup_pready", 32'(pready_w[0]), 32'd0);
         @(posedge clk); #1;
      end
      xfer(0, 1'b0, 32'd14, 32'd0);
      idle(0, 1);

      abort_write(0, 32'd7, 32'd99, 0);
      xfer(0, 1'b0, 32'd7, 32'd0);
      idle(0, 1);
      abort_write(2, 32'd7, 32'd99, 2);
      xfer(2, 1'b0, 32'd7, 32'd0);
      idle(2, 1);

      // Reset while the write of 15 to 31 sits in DONE.
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'd31; pwdata[0] = 32'd15;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      @(negedge clk);
      chk("rst_pre_wait", 32'(pready_w[0]), 32'd0);
      @(negedge clk);
      chk("rst_pre_done", 32'(pready_w[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      model_reset();
      bus_idle_all();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'd31, 32'd0);
      xfer(0, 1'b0, 32'd14, 32'd0);
      idle(0, 1);

      // Random traffic across all three instances.
      for (int i = 0; i < 90; i++) begin
         d  = int'($urandom_range(2, 0));
         wr = 1'($urandom_range(1, 0));
         wd = $urandom;
         case ($urandom_range(9, 0))
            0:       addr = 32'd32 + 32'($urandom_range(31, 0));
            1:       addr = (32'd1 << $urandom_range(31, 5)) | 32'($urandom_range(31, 0));
            default: addr = 32'($urandom_range(31, 0));
         endcase
         xfer(d, wr, addr, wd);
         if ($urandom_range(1, 0) == 1) idle(d, 1);
      end
      for (int dd = 0; dd < 3; dd++) begin
         idle(dd, 1);
         for (int a = 0; a < 32; a += 7) xfer(dd, 1'b0, 32'(a), 32'd0);
      end
      idle(0, 1); idle(1, 1); idle(2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
